// File: rtl/imersiv_mouse_event_in.sv
// imersiv_mouse_event_in
//
// Avalon-MM slave input port for mouse button/status lines. It brings the
// asynchronous in_port lines into the clk domain through a synchronizer and
// latches per-bit edges into a sticky capture register. It also counts edge
// cycles in a saturating counter and raises a maskable level interrupt.
//
// Register map (word addresses):
//   0 DATA    RO      synchronized in_port (writes ignored)
//   1 COUNT   RO/clr  saturating edge-event counter, any write clears
//   2 IRQMASK RW      per-bit interrupt enable
//   3 EDGECAP R/W1C   sticky per-bit edge flags
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   address    in   register word address
//   chipselect in   slave select
//   write_n    in   active-low write strobe, qualified by chipselect
//   writedata  in   write data (bits above WIDTH ignored)
//   readdata   out  registered read data, zero-extended, latency 1
//   in_port    in   asynchronous mouse status lines
//   irq        out  level interrupt, |(EDGECAP & IRQMASK)

module imersiv_mouse_event_in #(
  parameter int unsigned WIDTH     = 2,  // 1..32
  parameter int unsigned EDGE_TYPE = 0,  // 0 rising, 1 falling, 2 any
  parameter int unsigned CNT_W     = 16  // 1..32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrCount   = 2'd1;
  localparam logic [1:0] AddrIrqMask = 2'd2;
  localparam logic [1:0] AddrEdgeCap = 2'd3;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Synchronizer chain; s3 only exists to give edge detection a previous value.
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;

  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_edge_det;
  logic             w_edge_any;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_edgecap_d;
  logic [WIDTH-1:0] w_irqmask_d;
  logic [CNT_W-1:0] w_count_d;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  // Only the low WIDTH bits of writedata are meaningful.
  assign w_unused_wdata = ^writedata;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_wr           = chipselect & ~write_n;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection, selected at elaboration time
  // ---------------------------------------------------------------------------
  if (EDGE_TYPE == 0) begin : g_edge_rise
    assign w_edge_det = r_s2 & ~r_s3;
  end else if (EDGE_TYPE == 1) begin : g_edge_fall
    assign w_edge_det = ~r_s2 & r_s3;
  end else begin : g_edge_any
    assign w_edge_det = r_s2 ^ r_s3;
  end

  // Several bits edging in one cycle still count as a single event.
  assign w_edge_any = |w_edge_det;

  // ---------------------------------------------------------------------------
  // Next-state logic for the software-visible registers
  // ---------------------------------------------------------------------------
  always_comb begin
    w_w1c       = '0;
    w_irqmask_d = r_irqmask;
    w_count_d   = r_count;

    if (w_wr && (address == AddrEdgeCap)) begin
      w_w1c = w_wdata;
    end

    if (w_wr && (address == AddrIrqMask)) begin
      w_irqmask_d = w_wdata;
    end

    // A new edge beats a W1C of the same bit so no event is lost.
    w_edgecap_d = (r_edgecap & ~w_w1c) | w_edge_det;

    // Clear and increment in the same cycle leaves the new event counted.
    if (w_wr && (address == AddrCount)) begin
      w_count_d = w_edge_any ? CntOne : '0;
    end else if (w_edge_any && (r_count != CntMax)) begin
      w_count_d = r_count + CntOne;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
      r_irqmask <= '0;
      r_count   <= '0;
    end else begin
      r_edgecap <= w_edgecap_d;
      r_irqmask <= w_irqmask_d;
      r_count   <= w_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: registered every cycle, independent of chipselect
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_mux = '0;
    unique case (address)
      AddrData:    w_rd_mux[WIDTH-1:0] = r_s2;
      AddrCount:   w_rd_mux[CNT_W-1:0] = r_count;
      AddrIrqMask: w_rd_mux[WIDTH-1:0] = r_irqmask;
      AddrEdgeCap: w_rd_mux[WIDTH-1:0] = r_edgecap;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;

  // Level interrupt straight from registers; drops the cycle after the last
  // pending enabled flag is cleared or masked.
  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_imersiv_mouse_event_in.sv
// Directed bench for imersiv_mouse_event_in.
// Instance u_dut_a: WIDTH=2, EDGE_TYPE=0 (rising), CNT_W=16.
// Instance u_dut_b: WIDTH=2, EDGE_TYPE=2 (any),    CNT_W=2 for saturation.

module tb_imersiv_mouse_event_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_a;
  logic        cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [1:0]  in_a;
  logic [1:0]  in_b;
  logic        irq_a;
  logic        irq_b;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] va;
  logic [31:0] vb;

  always #5 clk = ~clk;

  imersiv_mouse_event_in #(
    .WIDTH    (2),
    .EDGE_TYPE(0),
    .CNT_W    (16)
  ) u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(cs_a),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (rd_a),
    .in_port   (in_a),
    .irq       (irq_a)
  );

  imersiv_mouse_event_in #(
    .WIDTH    (2),
    .EDGE_TYPE(2),
    .CNT_W    (2)
  ) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(cs_b),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (rd_b),
    .in_port   (in_b),
    .irq       (irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sel=0 targets u_dut_a, sel=1 targets u_dut_b
  task automatic wr(input bit sel, input logic [1:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    cs_a      = ~sel;
    cs_b      = sel;
    write_n   = 1'b0;
    tick(1);
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [31:0] a, output logic [31:0] b);
    address = addr;
    tick(1);
    a = rd_a;
    b = rd_b;
  endtask

  initial begin
    reset_n   = 1'b0;
    address   = 2'd0;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
    in_a      = 2'b00;
    in_b      = 2'b00;

    // Reset held: everything reads 0
    tick(2);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), va, vb);
      chk($sformatf("rst_hold_rd%0d", i), va, 32'h0);
    end
    chk("rst_hold_irq", {31'h0, irq_a}, 32'h0);

    // After release
    reset_n = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), va, vb);
      chk($sformatf("post_rst_rd%0d", i), va, 32'h0);
    end

    // Rising edge on bit0 with mask 01
    wr(1'b0, 2'd2, 32'h1);
    in_a = 2'b01;
    tick(2);
    chk("irq_before_e2", {31'h0, irq_a}, 32'h0);
    tick(1);
    chk("irq_at_e2", {31'h0, irq_a}, 32'h1);
    rd(2'd3, va, vb); chk("edgecap_01", va, 32'h1);
    rd(2'd1, va, vb); chk("count_1", va, 32'h1);
    rd(2'd0, va, vb); chk("data_01", va, 32'h1);
    rd(2'd2, va, vb); chk("irqmask_01", va, 32'h1);

    // W1C bit0
    wr(1'b0, 2'd3, 32'h1);
    chk("irq_after_w1c", {31'h0, irq_a}, 32'h0);
    rd(2'd3, va, vb); chk("edgecap_cleared", va, 32'h0);

    // Masked bit1 edge
    in_a = 2'b11;
    tick(3);
    chk("irq_masked", {31'h0, irq_a}, 32'h0);
    rd(2'd3, va, vb); chk("edgecap_10", va, 32'h2);
    rd(2'd1, va, vb); chk("count_2", va, 32'h2);
    wr(1'b0, 2'd3, 32'hFFFF_FFFF);
    rd(2'd3, va, vb); chk("edgecap_clr_all", va, 32'h0);

    // Falling edges ignored in rising mode, then both bits rise together
    in_a = 2'b00;
    tick(3);
    rd(2'd1, va, vb); chk("count_no_fall", va, 32'h2);
    rd(2'd3, va, vb); chk("edgecap_no_fall", va, 32'h0);
    in_a = 2'b11;
    tick(3);
    rd(2'd1, va, vb); chk("count_dual_once", va, 32'h3);
    rd(2'd3, va, vb); chk("edgecap_11", va, 32'h3);
    chk("irq_dual", {31'h0, irq_a}, 32'h1);

    // W1C of bit0 on the same edge where bit0 sets again
    wr(1'b0, 2'd3, 32'h3);
    chk("irq_clr_both", {31'h0, irq_a}, 32'h0);
    in_a = 2'b00;
    tick(3);
    in_a = 2'b01;
    tick(2);
    wr(1'b0, 2'd3, 32'h1);
    rd(2'd3, va, vb); chk("edgecap_set_wins", va, 32'h1);
    chk("irq_set_wins", {31'h0, irq_a}, 32'h1);
    rd(2'd1, va, vb); chk("count_4", va, 32'h4);

    // COUNT clear coincident with bit1 edge
    in_a = 2'b11;
    tick(2);
    wr(1'b0, 2'd1, 32'h0);
    rd(2'd1, va, vb); chk("count_clr_inc", va, 32'h1);
    rd(2'd3, va, vb); chk("edgecap_11_b", va, 32'h3);

    // Reset mid-operation
    wr(1'b0, 2'd2, 32'h3);
    chk("irq_mask11", {31'h0, irq_a}, 32'h1);
    in_a = 2'b00;
    tick(3);
    chk("irq_still", {31'h0, irq_a}, 32'h1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("irq_async_rst", {31'h0, irq_a}, 32'h0);
    chk("rd_async_rst", rd_a, 32'h0);
    #3;
    reset_n = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), va, vb);
      chk($sformatf("mid_rst_rd%0d", i), va, 32'h0);
    end

    // Saturation on u_dut_b (any edge, CNT_W=2)
    in_b = 2'b01;
    tick(3);
    in_b = 2'b00;
    tick(3);
    rd(2'd1, va, vb); chk("b_count_2", vb, 32'h2);
    in_b = 2'b01; tick(3);
    in_b = 2'b00; tick(3);
    in_b = 2'b01; tick(3);
    rd(2'd1, va, vb); chk("b_count_sat", vb, 32'h3);
    in_b = 2'b00;
    tick(3);
    rd(2'd1, va, vb); chk("b_count_hold", vb, 32'h3);
    rd(2'd3, va, vb); chk("b_edgecap", vb, 32'h1);
    chk("b_irq_masked", {31'h0, irq_b}, 32'h0);
    wr(1'b1, 2'd1, 32'h0);
    rd(2'd1, va, vb); chk("b_count_clr", vb, 32'h0);
    chk("a_count_untouched", va, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imersiv_mouse_event_in.md
# imersiv_mouse_event_in

Avalon-MM slave input port that carries mouse button/status lines from the USB/HID hardware side into the Nios II CPU. It is the reverse-direction counterpart of the CPU-driven mouse status output port. It synchronizes the asynchronous status lines and latches per-bit edges into a sticky capture register. It raises a maskable level interrupt and counts edge events for software polling or ISR use.

## Interface
- WIDTH, 2, number of status input bits (1..32)
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
- CNT_W, 16, event counter width (1..32), saturating
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low, clock clk
- address  in  2  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data, zero-extended
- in_port  in  WIDTH  asynchronous mouse status lines
- irq  out  1  level interrupt, active-high

## Operation
- Register map:
  - 0 DATA (RO): synchronized in_port. Writes are ignored.
  - 1 COUNT (RO/clear): event counter. Any write clears it.
  - 2 IRQMASK (RW): per-bit interrupt enable, writedata[WIDTH-1:0].
  - 3 EDGECAP (R/W1C): sticky per-bit edge flags. Writing 1 clears the bit; writing 0 leaves it.
- Write accepted when chipselect && !write_n. Upper writedata bits are ignored.
- Synchronizer: three-stage chain s1<=in_port, s2<=s1, s3<=s2. DATA reads s2.
- Edge detect (combinational), selected by EDGE_TYPE:
  - rising: s2 & ~s3
  - falling: ~s2 & s3
  - any: s2 ^ s3
- EDGECAP[i] sets on any cycle with edge_det[i]. It holds until W1C.
- Simultaneous edge_det[i] and W1C of bit i: set wins, so the bit stays 1.
- COUNT increments by exactly 1 on each cycle where |edge_det. Multiple bits edging in the same cycle count once.
- COUNT saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous COUNT clear and increment: COUNT becomes 1.
- irq = |(EDGECAP & IRQMASK), driven combinationally from registers.
- irq deasserts the cycle after the last pending masked bit is cleared or masked off.
- readdata is registered every clock from the address mux, regardless of chipselect. Unused upper bits read 0.
- Reset values: s1/s2/s3 = 0, EDGECAP = 0, IRQMASK = 0, COUNT = 0, readdata = 0, irq = 0.
- Reset asserted mid-operation clears all state immediately (asynchronously). No edge is reported on the first cycles after reset release unless in_port actually transitions relative to the reset value 0.
  - Exception: an in_port bit already high at reset release produces a rising edge 2 cycles after release. Software must clear EDGECAP after init.

## Timing
- Read latency is 1 cycle. readdata is valid the clock after address is presented, which matches an Avalon read latency setting of 1.
- Writes take effect at the clock edge where the write is sampled. A read of the same register on the next cycle returns the new value.
- Input-to-flag latency: in_port changes before edge E0.
  - s2 updates at E1.
  - EDGECAP, COUNT and irq update at E2.
  - readdata shows the new DATA at E2 and the new EDGECAP/COUNT at E3 if the address is held.
- An in_port pulse shorter than one clock may be missed. Pulses of 2 or more clocks are guaranteed to be captured.
- Throughput: one edge event per bit per clock.

## Test plan
- Reset state: hold reset_n=0, in_port=0. Readdata is 0 at all four addresses and irq=0. Release reset; all registers still read 0.
- Rising edge with mask, EDGE_TYPE=0:
  - Write IRQMASK=2'b01, then drive in_port 00->01.
  - At E2: EDGECAP=01, COUNT=1, irq=1.
  - Write 1 to EDGECAP bit0: irq=0 next cycle and EDGECAP reads 0.
- Masked bit: drive in_port bit1 0->1 with IRQMASK=01. Result is EDGECAP=10, COUNT increments, irq stays 0.
- Simultaneous events:
  - Both bits rise in the same cycle: COUNT +1 only, EDGECAP=11.
  - W1C of bit0 in the same cycle as a new bit0 edge: EDGECAP bit0 remains 1.
  - COUNT clear coincident with an edge: COUNT reads 1.
- Saturation: CNT_W=2, toggle in_port bit0 with EDGE_TYPE=2 five times. COUNT reads 3 and stays 3.
- Reset mid-operation: with EDGECAP=11, IRQMASK=11, irq=1, pulse reset_n low for half a cycle. irq drops immediately and every register reads 0 after reset release.
